// File: rtl/btn_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_mode_sequencer_pkg / btn_mode_sequencer_if
//  Description : Shared types and the board-side signal bundle of the button
//                mode sequencer. The sequencer connects to the "master"
//                modport; the board/datapath side connects to "slave".
//                Signals: BTNC/BTNU/BTND/BTNL/BTNR raw buttons, SW operand
//                switches, SELECTOR operation mode, DP_RESULT datapath
//                result, RESULT captured result, RESULT_VALID capture pulse,
//                BUSY settle/capture in progress, AUTO (AUTO_CYCLE_EN only).
//  Macro       : AUTO_CYCLE_EN adds the AUTO signal.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_mode_sequencer_pkg;
   typedef logic [15:0] word_t;

   typedef enum logic [2:0] {
      OP_RESET        = 3'd0,
      OP_ADD          = 3'd1,
      OP_SUB          = 3'd2,
      OP_MUL          = 3'd3,
      OP_LEADING_ONES = 3'd4,
      OP_COUNT_ONES   = 3'd5
   } opr_mode_t;
endpackage

interface btn_mode_sequencer_if;
   import btn_mode_sequencer_pkg::*;

   logic      BTNC;
   logic      BTNU;
   logic      BTND;
   logic      BTNL;
   logic      BTNR;
   word_t     SW;
   opr_mode_t SELECTOR;
   word_t     DP_RESULT;
   word_t     RESULT;
   logic      RESULT_VALID;
   logic      BUSY;
`ifdef AUTO_CYCLE_EN
   logic      AUTO;
`endif

   modport master (
      input  BTNC, BTNU, BTND, BTNL, BTNR, SW, DP_RESULT,
`ifdef AUTO_CYCLE_EN
      input  AUTO,
`endif
      output SELECTOR, RESULT, RESULT_VALID, BUSY
   );

   modport slave (
      output BTNC, BTNU, BTND, BTNL, BTNR, SW, DP_RESULT,
`ifdef AUTO_CYCLE_EN
      output AUTO,
`endif
      input  SELECTOR, RESULT, RESULT_VALID, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/btn_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_mode_sequencer
//  Description : Debounces five push buttons, turns press events into an
//                operation mode (SELECTOR), and after a settle wait captures
//                the datapath result into RESULT with a one-cycle
//                RESULT_VALID pulse. A change of the registered switches
//                triggers the same settle/capture sequence.
//  Ports       : CLK100MHZ  clock (rising edge)
//                RESET      synchronous active-high reset
//                bus        btn_mode_sequencer_if.master (buttons, SW,
//                           SELECTOR, DP_RESULT, RESULT, RESULT_VALID, BUSY)
//  Macro       : AUTO_CYCLE_EN adds AUTO input and AUTO_PERIOD parameter for
//                autonomous mode stepping while idle.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_mode_sequencer
   import btn_mode_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SETTLE_CYCLES   = 2
`ifdef AUTO_CYCLE_EN
   ,
   parameter int AUTO_PERIOD     = 16
`endif
) (
   input wire                   CLK100MHZ,
   input wire                   RESET,
   btn_mode_sequencer_if.master bus
);

   localparam int c_deb_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   // Button vectors are ordered {C, U, D, L, R}: higher index = higher priority.
   logic [4:0]         sync1_q, sync1_d;
   logic [4:0]         sync2_q, sync2_d;
   logic [4:0]         deb_q, deb_d;
   logic [4:0]         deb_prev_q, deb_prev_d;
   logic [c_deb_w-1:0] deb_cnt_q [5];
   logic [c_deb_w-1:0] deb_cnt_d [5];
   logic [4:0]         rise;
   logic               evt_vld_q, evt_vld_d;
   opr_mode_t          evt_mode_q, evt_mode_d;
   opr_mode_t          sel_q, sel_d;
   word_t              sw_q, sw_d;
   state_t             state_q, state_d;
   logic [7:0]         settle_cnt_q, settle_cnt_d;
   word_t              result_q, result_d;
   logic               rv_q, rv_d;
   logic               go;

`ifdef AUTO_CYCLE_EN
   localparam int c_auto_w = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   logic [c_auto_w-1:0] auto_cnt_q, auto_cnt_d;

   function automatic opr_mode_t next_mode(input opr_mode_t m);
      case (m)
         OP_ADD:          return OP_SUB;
         OP_SUB:          return OP_MUL;
         OP_MUL:          return OP_LEADING_ONES;
         OP_LEADING_ONES: return OP_COUNT_ONES;
         default:         return OP_ADD;
      endcase
   endfunction
`endif

   always_comb begin
      sync1_d    = {bus.BTNC, bus.BTNU, bus.BTND, bus.BTNL, bus.BTNR};
      sync2_d    = sync1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      for (int i = 0; i < 5; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == c_deb_w'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + c_deb_w'(1);
            end
         end
      end

      // Press events are registered once so SELECTOR loads one clock later.
      rise       = deb_q & ~deb_prev_q;
      evt_vld_d  = |rise;
      evt_mode_d = OP_RESET;
      if (rise[4])      evt_mode_d = OP_MUL;
      else if (rise[3]) evt_mode_d = OP_LEADING_ONES;
      else if (rise[2]) evt_mode_d = OP_COUNT_ONES;
      else if (rise[1]) evt_mode_d = OP_ADD;
      else if (rise[0]) evt_mode_d = OP_SUB;

`ifdef AUTO_CYCLE_EN
      auto_cnt_d = '0;
      if (!(|rise) && !evt_vld_q && bus.AUTO && (state_q == ST_IDLE)) begin
         if (auto_cnt_q == c_auto_w'(AUTO_PERIOD - 1)) begin
            evt_vld_d  = 1'b1;
            evt_mode_d = next_mode(sel_q);
         end else begin
            auto_cnt_d = auto_cnt_q + c_auto_w'(1);
         end
      end
`endif

      sw_d  = bus.SW;
      sel_d = evt_vld_q ? evt_mode_q : sel_q;
      // The edge that loads SELECTOR or the new switch value also enters SETTLE.
      go    = evt_vld_q | (bus.SW != sw_q);

      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      result_d     = result_q;
      rv_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
            end
         end
         ST_SETTLE: begin
            if (go) begin
               settle_cnt_d = '0;
            end else if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
               state_d      = ST_CAPTURE;
               settle_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + 8'd1;
            end
         end
         ST_CAPTURE: begin
            result_d     = bus.DP_RESULT;
            rv_d         = 1'b1;
            settle_cnt_d = '0;
            state_d      = go ? ST_SETTLE : ST_IDLE;
         end
         default: begin
            state_d      = ST_IDLE;
            settle_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_prev_q   <= '0;
         for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
         evt_vld_q    <= 1'b0;
         evt_mode_q   <= OP_RESET;
         sel_q        <= OP_RESET;
         sw_q         <= '0;
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         result_q     <= '0;
         rv_q         <= 1'b0;
`ifdef AUTO_CYCLE_EN
         auto_cnt_q   <= '0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_q        <= deb_d;
         deb_prev_q   <= deb_prev_d;
         for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         evt_vld_q    <= evt_vld_d;
         evt_mode_q   <= evt_mode_d;
         sel_q        <= sel_d;
         sw_q         <= sw_d;
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         result_q     <= result_d;
         rv_q         <= rv_d;
`ifdef AUTO_CYCLE_EN
         auto_cnt_q   <= auto_cnt_d;
`endif
      end
   end

   assign bus.SELECTOR     = sel_q;
   assign bus.RESULT       = result_q;
   assign bus.RESULT_VALID = rv_q;
   assign bus.BUSY         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_btn_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_mode_sequencer
//  Description : Directed self-checking bench for btn_mode_sequencer with
//                DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2. A simple datapath
//                model returns {SELECTOR, SW[12:0]} as DP_RESULT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_mode_sequencer;
   import btn_mode_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   rv_cnt = 0;
   int   rv_snap;

   btn_mode_sequencer_if bus ();

   btn_mode_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .SETTLE_CYCLES   (2)
   ) u_dut (
      .CLK100MHZ (clk),
      .RESET     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.DP_RESULT = {bus.SELECTOR, 13'h0} | (bus.SW & 16'h1FFF);

   always @(negedge clk) if (bus.RESULT_VALID === 1'b1) rv_cnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Advance n rising edges, then sit 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.BTNC = 1'b0; bus.BTNU = 1'b0; bus.BTND = 1'b0;
      bus.BTNL = 1'b0; bus.BTNR = 1'b0; bus.SW = 16'h0000;
`ifdef AUTO_CYCLE_EN
      bus.AUTO = 1'b0;
`endif
      step(3);
      chk("rst_sel",  32'(bus.SELECTOR), 32'(OP_RESET));
      chk("rst_res",  32'(bus.RESULT), 32'h0);
      chk("rst_rv",   32'(bus.RESULT_VALID), 32'h0);
      chk("rst_busy", 32'(bus.BUSY), 32'h0);

      // BTNL held from edge 0
      rst = 1'b0; bus.BTNL = 1'b1;
      step(7);
      chk("l_sel_e6",  32'(bus.SELECTOR), 32'(OP_RESET));
      chk("l_busy_e6", 32'(bus.BUSY), 32'h0);
      step(1);
      chk("l_sel_e7",  32'(bus.SELECTOR), 32'(OP_ADD));
      chk("l_busy_e7", 32'(bus.BUSY), 32'h1);
      step(2);
      chk("l_busy_e9", 32'(bus.BUSY), 32'h1);
      chk("l_rv_e9",   32'(bus.RESULT_VALID), 32'h0);
      step(1);
      chk("l_rv_e10",   32'(bus.RESULT_VALID), 32'h1);
      chk("l_res_e10",  32'(bus.RESULT), 32'h2000);
      chk("l_busy_e10", 32'(bus.BUSY), 32'h0);
      step(1);
      chk("l_rv_e11",  32'(bus.RESULT_VALID), 32'h0);
      bus.BTNL = 1'b0;
      step(10);
      chk("l_res_hold", 32'(bus.RESULT), 32'h2000);

      // BTNR glitch of 3 clocks
      rv_snap = rv_cnt;
      bus.BTNR = 1'b1; step(3); bus.BTNR = 1'b0;
      step(15);
      chk("glitch_sel", 32'(bus.SELECTOR), 32'(OP_ADD));
      chk("glitch_rv",  32'(rv_cnt - rv_snap), 32'h0);

      // BTNC + BTNU same cycle
      rv_snap = rv_cnt;
      bus.BTNC = 1'b1; bus.BTNU = 1'b1;
      step(7);
      chk("cu_sel_e6", 32'(bus.SELECTOR), 32'(OP_ADD));
      step(1);
      chk("cu_sel_e7", 32'(bus.SELECTOR), 32'(OP_MUL));
      step(3);
      chk("cu_rv",  32'(bus.RESULT_VALID), 32'h1);
      chk("cu_res", 32'(bus.RESULT), 32'h6000);
      bus.BTNC = 1'b0; bus.BTNU = 1'b0;
      step(12);
      chk("cu_sel_end", 32'(bus.SELECTOR), 32'(OP_MUL));
      chk("cu_nrv",     32'(rv_cnt - rv_snap), 32'h1);

      // BTND, then BTNL one clock later: ADD lands one clock into SETTLE
      rv_snap = rv_cnt;
      bus.BTND = 1'b1; step(1); bus.BTNL = 1'b1;
      step(7);
      chk("dl_sel_d", 32'(bus.SELECTOR), 32'(OP_COUNT_ONES));
      step(1);
      chk("dl_sel_l", 32'(bus.SELECTOR), 32'(OP_ADD));
      step(2);
      chk("dl_rv_e10", 32'(bus.RESULT_VALID), 32'h0);
      step(1);
      chk("dl_rv_e11",  32'(bus.RESULT_VALID), 32'h1);
      chk("dl_res_e11", 32'(bus.RESULT), 32'h2000);
      bus.BTND = 1'b0; bus.BTNL = 1'b0;
      step(12);
      chk("dl_nrv", 32'(rv_cnt - rv_snap), 32'h1);

      // SW recompute with SELECTOR=SUB
      bus.BTNR = 1'b1; step(12); bus.BTNR = 1'b0; step(10);
      chk("sub_sel", 32'(bus.SELECTOR), 32'(OP_SUB));
      bus.SW = 16'h0003; step(8);
      chk("sw3_res", 32'(bus.RESULT), 32'h4003);
      rv_snap = rv_cnt;
      bus.SW = 16'h0005;
      step(3);
      chk("sw5_rv_e2", 32'(bus.RESULT_VALID), 32'h0);
      chk("sw5_busy",  32'(bus.BUSY), 32'h1);
      step(1);
      chk("sw5_rv_e3", 32'(bus.RESULT_VALID), 32'h1);
      chk("sw5_res",   32'(bus.RESULT), 32'h4005);
      chk("sw5_sel",   32'(bus.SELECTOR), 32'(OP_SUB));
      step(4);
      chk("sw5_nrv", 32'(rv_cnt - rv_snap), 32'h1);

      // Recompute event arriving during CAPTURE
      rv_snap = rv_cnt;
      bus.SW = 16'h0001; step(3);
      chk("cap_busy_pre", 32'(bus.BUSY), 32'h1);
      bus.SW = 16'h0002; step(1);
      chk("cap_rv1",   32'(bus.RESULT_VALID), 32'h1);
      chk("cap_res1",  32'(bus.RESULT), 32'h4002);
      chk("cap_busy1", 32'(bus.BUSY), 32'h1);
      step(3);
      chk("cap_rv2",  32'(bus.RESULT_VALID), 32'h1);
      step(3);
      chk("cap_nrv", 32'(rv_cnt - rv_snap), 32'h2);

      // RESET in SETTLE aborts the capture
      rv_snap = rv_cnt;
      bus.SW = 16'h0007; step(2);
      chk("abort_busy", 32'(bus.BUSY), 32'h1);
      rst = 1'b1; bus.SW = 16'h0000; step(1);
      chk("abort_sel",  32'(bus.SELECTOR), 32'(OP_RESET));
      chk("abort_res",  32'(bus.RESULT), 32'h0);
      chk("abort_busy0", 32'(bus.BUSY), 32'h0);
      rst = 1'b0; step(8);
      chk("abort_nrv", 32'(rv_cnt - rv_snap), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/btn_mode_sequencer.md
BTN_MODE_SEQUENCER -- requirements
Module: btn_mode_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable raw samples required to accept a button level change (board build uses 1000000).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, datapath settle wait before result capture (range 1..255).
REQ-003 SHALL have port CLK100MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports BTNC, BTNU, BTND, BTNL, BTNR  input  1 each  raw asynchronous push buttons.
REQ-006 SHALL have port SW  input  word_t  operand switches, passed unchanged to the datapath.
REQ-007 SHALL have port SELECTOR  output  opr_mode_t  registered operation mode driven to select_action.
REQ-008 SHALL have port DP_RESULT  input  word_t  combinational result returned from select_action LED.
REQ-009 SHALL have port RESULT  output  word_t  registered captured result.
REQ-010 SHALL have port RESULT_VALID  output  1  one-cycle pulse when RESULT updates.
REQ-011 SHALL have port BUSY  output  1  high in SETTLE and CAPTURE states.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a per-button debounce counter; debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples differing from it; any matching sample clears the counter.
REQ-013 SHALL treat a debounced 0->1 transition as a press event; releases and held levels generate no events.
REQ-014 SHALL resolve same-cycle press events by fixed priority BTNC=MUL > BTNU=LEADING_ONES > BTND=COUNT_ONES > BTNL=ADD > BTNR=SUB; lower presses are discarded.
REQ-015 SHALL load SELECTOR one clock after the press event; raw press stable from edge 0 yields new SELECTOR after edge DEBOUNCE_CYCLES+3.
REQ-016 SHALL register SW each cycle; a registered-SW change is a recompute event with the same timing as a press, SELECTOR unchanged.
REQ-017 SHALL implement FSM IDLE -> SETTLE on any press or recompute event; SETTLE counts SETTLE_CYCLES clocks then -> CAPTURE; CAPTURE loads RESULT from DP_RESULT, pulses RESULT_VALID, -> IDLE.
REQ-018 SHALL assert RESULT_VALID exactly SETTLE_CYCLES+1 clocks after SELECTOR (or registered SW) changes, for one clock.
REQ-019 SHALL on a press or recompute event in SETTLE update SELECTOR and restart the settle count at zero (latest wins, no intermediate capture).
REQ-020 SHALL on an event in CAPTURE still complete the capture and pulse, then enter SETTLE instead of IDLE.
REQ-021 SHALL hold RESULT stable between captures.

Reset
REQ-022 SHALL on RESET set SELECTOR=RESET, RESULT=0, RESULT_VALID=0, BUSY=0, FSM=IDLE, all synchronizer, debounce and settle state to 0, registered SW to 0.
REQ-023 SHALL, for a button held through reset release, report a press DEBOUNCE_CYCLES+2 clocks after release (debounced level starts at 0).
REQ-024 SHALL let RESET mid-SETTLE/CAPTURE abort with no RESULT_VALID pulse.
REQ-025 SHALL give RESET priority over all events in the same cycle.

Configuration
REQ-026 SHALL, with AUTO_CYCLE_EN defined, add input AUTO (1 bit) and parameter AUTO_PERIOD (default 16): while AUTO=1 and FSM=IDLE for AUTO_PERIOD consecutive clocks, advance SELECTOR ADD->SUB->MUL->LEADING_ONES->COUNT_ONES->ADD (from RESET go to ADD) as a press event; button presses override and restart the period count.
REQ-027 SHALL, without AUTO_CYCLE_EN, have no AUTO port, no AUTO_PERIOD parameter and no autonomous mode change.

Verification (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2)
REQ-028 Reset, then BTNL held from edge 0 -> SELECTOR=ADD after edge 7, BUSY high edges 7-9, RESULT=DP_RESULT and RESULT_VALID pulse after edge 10.
REQ-029 BTNR raw glitch high 3 clocks then low -> no SELECTOR change, no RESULT_VALID.
REQ-030 BTNC and BTNU pressed same cycle -> SELECTOR=MUL only, exactly one RESULT_VALID.
REQ-031 BTND press event, then BTNL press event 1 clock into SETTLE -> final SELECTOR=ADD, single RESULT_VALID 3 clocks after the ADD load.
REQ-032 SW 0x0003->0x0005 in IDLE with SELECTOR=SUB -> SELECTOR unchanged, RESULT_VALID 3 clocks after registered SW change, RESULT=DP_RESULT.
REQ-033 RESET asserted in SETTLE -> SELECTOR=RESET, RESULT=0, no RESULT_VALID; (AUTO_CYCLE_EN) AUTO=1 from IDLE with SELECTOR=RESET -> SELECTOR=ADD after 16 clocks.
